// File: rtl/mips_pkg.sv
// Shared encodings, stage-register bundles and decode/ALU helpers for the
// five-stage MIPS integer core.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   typedef enum logic [1:0] {
      FWD_REG,
      FWD_EXMEM,
      FWD_MEMWB
   } fwd_sel_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       use_imm;
      logic       use_rs;
      logic       use_rt;
      alu_op_t    alu_op;
      logic [4:0] dest;
   } ctrl_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_t;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        use_imm;
      alu_op_t     alu_op;
      logic [4:0]  dest;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] pc;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
   } idex_t;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [4:0]  dest;
      logic [31:0] alu_res;
      logic [31:0] store_val;
   } exmem_t;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic [4:0]  dest;
      logic [31:0] data;
   } memwb_t;

   // Anything not listed decodes to an all-zero control word, i.e. a NOP.
   function automatic ctrl_t decode(input logic [31:0] ins);
      ctrl_t c;
      c = '0;
      c.alu_op = ALU_ADD;
      case (ins[31:26])
         OP_RTYPE: begin
            c.reg_write = 1'b1;
            c.use_rs    = 1'b1;
            c.use_rt    = 1'b1;
            c.dest      = ins[15:11];
            case (ins[5:0])
               FN_ADD:  c.alu_op = ALU_ADD;
               FN_SUB:  c.alu_op = ALU_SUB;
               FN_AND:  c.alu_op = ALU_AND;
               FN_OR:   c.alu_op = ALU_OR;
               FN_SLT:  c.alu_op = ALU_SLT;
               default: c = '0;
            endcase
         end
         OP_ADDI: begin
            c.reg_write = 1'b1;
            c.use_imm   = 1'b1;
            c.use_rs    = 1'b1;
            c.dest      = ins[20:16];
         end
         OP_LW: begin
            c.reg_write = 1'b1;
            c.mem_read  = 1'b1;
            c.use_imm   = 1'b1;
            c.use_rs    = 1'b1;
            c.dest      = ins[20:16];
         end
         OP_SW: begin
            c.mem_write = 1'b1;
            c.use_imm   = 1'b1;
            c.use_rs    = 1'b1;
            c.use_rt    = 1'b1;
         end
         OP_BEQ: begin
            c.branch = 1'b1;
            c.use_rs = 1'b1;
            c.use_rt = 1'b1;
            c.alu_op = ALU_SUB;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
         default: r = a + b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// Operand-forwarding selects for EX and the ID-stage stall decision, for
// either the forwarding build or the stall-only build.
module mips_hazard_unit
   import mips_pkg::*;
#(
   parameter int FWD_EN = 1
) (
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       ex_valid,
   input  logic       ex_reg_write,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_dest,
   input  logic [4:0] ex_rs,
   input  logic [4:0] ex_rt,
   input  logic       mem_valid,
   input  logic       mem_reg_write,
   input  logic [4:0] mem_dest,
   input  logic       wb_valid,
   input  logic       wb_reg_write,
   input  logic [4:0] wb_dest,
   input  logic       branch_taken,
   output logic       stall,
   output fwd_sel_t   fwd_a,
   output fwd_sel_t   fwd_b
);

   logic ex_wr;
   logic mem_wr;
   logic wb_wr;
   logic hazard;

   function automatic logic hit(input logic [4:0] dest, input logic [4:0] src, input logic used);
      return used && (src != 5'd0) && (dest == src);
   endfunction

   assign ex_wr  = ex_valid & ex_reg_write;
   assign mem_wr = mem_valid & mem_reg_write;
   assign wb_wr  = wb_valid & wb_reg_write;

   always_comb begin
      hazard = 1'b0;
      fwd_a  = FWD_REG;
      fwd_b  = FWD_REG;
      if (FWD_EN != 0) begin
         // Only a load still in EX cannot be forwarded in time.
         hazard = ex_wr & ex_mem_read &
                  (hit(ex_dest, id_rs, id_use_rs) | hit(ex_dest, id_rt, id_use_rt));
         if (hit(mem_dest, ex_rs, mem_wr))
            fwd_a = FWD_EXMEM;
         else if (hit(wb_dest, ex_rs, wb_wr))
            fwd_a = FWD_MEMWB;
         if (hit(mem_dest, ex_rt, mem_wr))
            fwd_b = FWD_EXMEM;
         else if (hit(wb_dest, ex_rt, wb_wr))
            fwd_b = FWD_MEMWB;
      end else begin
         hazard = (ex_wr  & (hit(ex_dest,  id_rs, id_use_rs) | hit(ex_dest,  id_rt, id_use_rt))) |
                  (mem_wr & (hit(mem_dest, id_rs, id_use_rs) | hit(mem_dest, id_rt, id_use_rt)));
      end
      stall = id_valid & hazard & ~branch_taken;
   end

endmodule

// File: rtl/mips_pipeline_core.sv
// Five-stage MIPS integer pipeline (IF/ID/EX/MEM/WB) with inline register
// file and data memory; instruction memory lives outside and answers pc_out.
module mips_pipeline_core
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          DMEM_DEPTH = 64,
   parameter int          FWD_EN     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic        wr_en,
   output logic [4:0]  wr_reg,
   output logic [31:0] wr_dat,
   output logic        stall
);

   localparam int AW = $clog2(DMEM_DEPTH);

   logic [31:0] pc_reg;
   ifid_t       ifid_reg;
   idex_t       idex_reg;
   idex_t       idex_next;
   exmem_t      exmem_reg;
   exmem_t      exmem_next;
   memwb_t      memwb_reg;
   memwb_t      memwb_next;

   logic [31:0] rf   [32];
   logic [31:0] dmem [DMEM_DEPTH];

   ctrl_t       id_ctrl;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [31:0] id_rs_val;
   logic [31:0] id_rt_val;
   logic [31:0] id_imm;

   fwd_sel_t    fwd_a;
   fwd_sel_t    fwd_b;
   logic [31:0] ex_a;
   logic [31:0] ex_b_reg;
   logic [31:0] ex_b;
   logic [31:0] ex_res;
   logic        branch_taken;
   logic [31:0] br_target;

   logic [AW-1:0] mem_idx;
   logic [31:0]   mem_rdata;

   assign pc_out = pc_reg;

   // ---------------- ID ----------------
   assign id_ctrl = decode(ifid_reg.instr);
   assign id_rs   = ifid_reg.instr[25:21];
   assign id_rt   = ifid_reg.instr[20:16];
   assign id_imm  = {{16{ifid_reg.instr[15]}}, ifid_reg.instr[15:0]};

   // Write-through so an ID read sees the value WB is writing this cycle.
   assign id_rs_val = (wr_en && wr_reg == id_rs && id_rs != 5'd0) ? wr_dat : rf[id_rs];
   assign id_rt_val = (wr_en && wr_reg == id_rt && id_rt != 5'd0) ? wr_dat : rf[id_rt];

   always_comb begin
      idex_next           = '0;
      idex_next.valid     = ifid_reg.valid & ~stall & ~branch_taken;
      idex_next.reg_write = id_ctrl.reg_write;
      idex_next.mem_read  = id_ctrl.mem_read;
      idex_next.mem_write = id_ctrl.mem_write;
      idex_next.branch    = id_ctrl.branch;
      idex_next.use_imm   = id_ctrl.use_imm;
      idex_next.alu_op    = id_ctrl.alu_op;
      idex_next.dest      = id_ctrl.dest;
      idex_next.rs        = id_rs;
      idex_next.rt        = id_rt;
      idex_next.pc        = ifid_reg.pc;
      idex_next.rs_val    = id_rs_val;
      idex_next.rt_val    = id_rt_val;
      idex_next.imm       = id_imm;
   end

   mips_hazard_unit #(
      .FWD_EN(FWD_EN)
   ) u_hazard (
      .id_valid     (ifid_reg.valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_ctrl.use_rs),
      .id_use_rt    (id_ctrl.use_rt),
      .ex_valid     (idex_reg.valid),
      .ex_reg_write (idex_reg.reg_write),
      .ex_mem_read  (idex_reg.mem_read),
      .ex_dest      (idex_reg.dest),
      .ex_rs        (idex_reg.rs),
      .ex_rt        (idex_reg.rt),
      .mem_valid    (exmem_reg.valid),
      .mem_reg_write(exmem_reg.reg_write),
      .mem_dest     (exmem_reg.dest),
      .wb_valid     (memwb_reg.valid),
      .wb_reg_write (memwb_reg.reg_write),
      .wb_dest      (memwb_reg.dest),
      .branch_taken (branch_taken),
      .stall        (stall),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   // ---------------- EX ----------------
   always_comb begin
      case (fwd_a)
         FWD_EXMEM: ex_a = exmem_reg.alu_res;
         FWD_MEMWB: ex_a = memwb_reg.data;
         default:   ex_a = idex_reg.rs_val;
      endcase
      case (fwd_b)
         FWD_EXMEM: ex_b_reg = exmem_reg.alu_res;
         FWD_MEMWB: ex_b_reg = memwb_reg.data;
         default:   ex_b_reg = idex_reg.rt_val;
      endcase
   end

   assign ex_b         = idex_reg.use_imm ? idex_reg.imm : ex_b_reg;
   assign ex_res       = alu(idex_reg.alu_op, ex_a, ex_b);
   assign branch_taken = idex_reg.valid & idex_reg.branch & (ex_a == ex_b_reg);
   assign br_target    = idex_reg.pc + 32'd4 + (idex_reg.imm << 2);

   always_comb begin
      exmem_next           = '0;
      exmem_next.valid     = idex_reg.valid;
      exmem_next.reg_write = idex_reg.reg_write;
      exmem_next.mem_read  = idex_reg.mem_read;
      exmem_next.mem_write = idex_reg.mem_write;
      exmem_next.dest      = idex_reg.dest;
      exmem_next.alu_res   = ex_res;
      exmem_next.store_val = ex_b_reg;
   end

   // ---------------- MEM ----------------
   assign mem_idx   = exmem_reg.alu_res[AW+1:2];
   assign mem_rdata = dmem[mem_idx];

   always_comb begin
      memwb_next           = '0;
      memwb_next.valid     = exmem_reg.valid;
      memwb_next.reg_write = exmem_reg.reg_write;
      memwb_next.dest      = exmem_reg.dest;
      memwb_next.data      = exmem_reg.mem_read ? mem_rdata : exmem_reg.alu_res;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DMEM_DEPTH; i++)
            dmem[i] <= '0;
      end else if (exmem_reg.valid && exmem_reg.mem_write) begin
         dmem[mem_idx] <= exmem_reg.store_val;
      end
   end

   // ---------------- WB ----------------
   assign wr_en  = memwb_reg.valid & memwb_reg.reg_write;
   assign wr_reg = wr_en ? memwb_reg.dest : 5'd0;
   assign wr_dat = wr_en ? memwb_reg.data : 32'd0;

   // Entry 0 is cleared by reset and never written, so it always reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= '0;
      end else if (wr_en && wr_reg != 5'd0) begin
         rf[wr_reg] <= wr_dat;
      end
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg    <= RESET_PC;
         ifid_reg  <= '0;
         idex_reg  <= '0;
         exmem_reg <= '0;
         memwb_reg <= '0;
      end else begin
         if (branch_taken) begin
            pc_reg         <= br_target;
            ifid_reg.valid <= 1'b0;
         end else if (!stall) begin
            pc_reg   <= pc_reg + 32'd4;
            ifid_reg <= '{valid: 1'b1, pc: pc_reg, instr: instr};
         end
         idex_reg  <= idex_next;
         exmem_reg <= exmem_next;
         memwb_reg <= memwb_next;
      end
   end

endmodule

// File: doc/mips_pipeline_core.md
MIPS_PIPELINE_CORE -- requirements
Module: mips_pipeline_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter DMEM_DEPTH, default 64, meaning the number of 32-bit data-memory words (power of 2).
REQ-003 SHALL have parameter FWD_EN, default 1, meaning 1 = EX/MEM and MEM/WB forwarding, 0 = stall-only hazard resolution.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port instr, input, 32 bits: the instruction word at pc_out, valid combinationally in the same cycle.
REQ-007 SHALL have port pc_out, output, 32 bits: the fetch address.
REQ-008 SHALL have port wr_en, output, 1 bit: a WB-stage register write occurs this cycle.
REQ-009 SHALL have port wr_reg, output, 5 bits: the WB destination register.
REQ-010 SHALL have port wr_dat, output, 32 bits: the WB write data.
REQ-011 SHALL have port stall, output, 1 bit: PC and IF/ID held this cycle.

Function
REQ-012 SHALL implement 5 stages (IF, ID, EX, MEM, WB) with a valid bit per stage register.
REQ-013 SHALL decode the following; every other opcode/funct SHALL execute as a NOP (no write, no memory access):
- R-type (op 0) funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed)
- op 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq
REQ-014 SHALL sign-extend immediates to 32 bits; arithmetic SHALL be 32-bit wrap-around with no overflow trap.
REQ-015 SHALL hard-wire register 0 to zero; a write to reg 0 SHALL assert wr_en with no state change, and reg 0 SHALL never be a forwarding source.
REQ-016 SHALL, when the register file is read in ID the same cycle WB writes that register, return the WB data.
REQ-017 SHALL drive wr_en/wr_reg/wr_dat combinationally from MEM/WB; an instruction fetched in cycle n SHALL appear there in cycle n+4 absent stalls/flushes.
REQ-018 SHALL, when FWD_EN=1, forward EX operands from EX/MEM (ALU result) over MEM/WB (WB data), EX/MEM having priority; the sw store-data operand SHALL also be forwarded.
REQ-019 SHALL, when FWD_EN=1, handle a lw in EX whose rt matches a used source of the ID instruction as a load-use hazard: stall one cycle, hold PC and IF/ID, and inject a bubble into ID/EX.
REQ-020 SHALL, when FWD_EN=0, stall while any valid writing instruction in EX or MEM targets a nonzero source register of the ID instruction.
REQ-021 SHALL resolve beq in EX: when taken, pc_out on the next edge = PC_beq+4+(imm<<2), IF/ID and ID/EX are invalidated, and the penalty is 2 cycles; not-taken SHALL have no penalty.
REQ-022 SHALL give a taken branch priority over a stall in the same cycle; the flush SHALL cancel the stall.
REQ-023 SHALL implement data memory as DMEM_DEPTH words with a synchronous write in MEM and an asynchronous read, indexed by address[log2(DMEM_DEPTH)+1:2]; upper address bits SHALL be ignored (wrap-around).
REQ-024 SHALL assert stall only on hazard cycles; pc_out SHALL advance by 4 on every other non-branch cycle.

Reset
REQ-025 SHALL, on rst_n low, asynchronously set pc_out=RESET_PC, clear all stage valid bits, set wr_en=0, wr_reg=0, wr_dat=0, stall=0, and zero every register and data-memory word.
REQ-026 SHALL, on reset asserted mid-operation, discard all in-flight instructions; no write SHALL occur after release until refilled instructions reach WB.
REQ-027 SHALL fetch RESET_PC on the first rising edge after release.

Structure
REQ-028 SHALL take opcode/funct constants, ALU operation encodings, and the stage-register bundle typedefs from shared package mips_pkg.
REQ-029 SHALL place forwarding-select and stall logic in a single sub-module, mips_hazard_unit; the register file and data memory SHALL be inline.

Verification
REQ-030 Test: addi $1,$0,5; add $2,$1,$1 back-to-back, FWD_EN=1 -> wr_reg=2, wr_dat=10, stall never asserted.
REQ-031 Test: same program with FWD_EN=0 -> wr_dat=10 for reg 2, stall high exactly 2 cycles.
REQ-032 Test: sw $1,8($0) ($1=5); lw $3,8($0); add $4,$3,$3 -> stall high 1 cycle, wr_reg=4, wr_dat=10.
REQ-033 Test: beq $0,$0,+2 at PC 0x10 -> next pc_out=0x1C, the two younger instructions never assert wr_en.
REQ-034 Test: addi $0,$0,7 then add $5,$0,$0 -> wr_dat=0 for reg 5.
REQ-035 Test: rst_n pulsed low while 4 instructions are in flight -> pc_out=RESET_PC and wr_en=0 for 4 cycles after release.
